// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//   SPI slave that turns SPI frames into register-bus accesses. The first word
//   of a frame is a command (MSB = 1 write, 0 read; low ADDR_WIDTH bits = base
//   address). Following words are written to, or read from, consecutive
//   addresses. The SPI pins are asynchronous and oversampled by clk.
//
// Ports
//   clk      in   system clock, all logic on its rising edge
//   reset    in   synchronous, active-high reset
//   cs       in   SPI chip select, active low (asynchronous)
//   sck      in   SPI clock (asynchronous)
//   mosi     in   SPI data in (asynchronous)
//   miso     out  SPI data out, registered, MSB first
//   addr     out  register address, registered
//   wrData   out  write data, registered
//   wrEn     out  one-clk write strobe
//   rdEn     out  one-clk read request
//   rdData   in   read data, valid the clk after rdEn
//   busy     out  high while a frame is active
//   frameErr out  one-clk pulse when cs rises with a partial word received
// -----------------------------------------------------------------------------
module spi_reg_slave #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  sck,
   input  logic                  mosi,
   output logic                  miso,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [WIDTH-1:0]      wrData,
   output logic                  wrEn,
   output logic                  rdEn,
   input  logic [WIDTH-1:0]      rdData,
   output logic                  busy,
   output logic                  frameErr
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic             SCK_IDLE = (CPOL != 0);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   // Pin synchronizers: two flops against metastability, a third for edges.
   logic cs_meta_q, cs_sync_q, cs_dly_q;
   logic sck_meta_q, sck_sync_q, sck_dly_q;
   logic mosi_meta_q, mosi_sync_q;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WIDTH-2:0]      rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0]      tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0]      next_tx_q, next_tx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wr_data_q, wr_data_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  rd_cap_q, rd_cap_d;
   logic                  load_pend_q, load_pend_d;
   logic                  frame_err_q, frame_err_d;
   logic                  busy_q, busy_d;
   logic                  miso_q, miso_d;

   logic             cs_fall, cs_rise;
   logic             lead_edge, trail_edge, sample_edge, shift_edge;
   logic             word_done;
   logic [WIDTH-1:0] rx_word;

   assign cs_fall     = cs_dly_q & ~cs_sync_q;
   assign cs_rise     = ~cs_dly_q & cs_sync_q;
   assign lead_edge   = (sck_dly_q == SCK_IDLE) && (sck_sync_q != SCK_IDLE);
   assign trail_edge  = (sck_dly_q != SCK_IDLE) && (sck_sync_q == SCK_IDLE);
   assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
   assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
   // mosi_sync_q has the same latency as sck_sync_q, so it is the bit on the pin
   // at the sample edge being detected.
   assign rx_word     = {rx_shift_q, mosi_sync_q};
   assign word_done   = sample_edge && (bit_cnt_q == LAST_BIT);

   always_comb begin
      // NOTE: every _d gets a default before any branch, so no latch is inferred.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      next_tx_d   = next_tx_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      rd_cap_d    = 1'b0;
      load_pend_d = load_pend_q;
      frame_err_d = 1'b0;

      // The address advances the clk after each strobe, so every strobe is
      // presented with the address it refers to.
      if (wr_en_q || rd_en_q) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
      end
      // rdData is valid the clk after rdEn; capture it then.
      rd_cap_d = rd_en_q;

      if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d     = CMD;
            bit_cnt_d   = '0;
            tx_shift_d  = '0;
            load_pend_d = 1'b0;
         end
      end else if (cs_rise) begin
         // cs rising wins over a sample edge in the same clk: the partial word
         // is dropped and no further strobes are issued.
         state_d     = IDLE;
         frame_err_d = (bit_cnt_q != '0);
         bit_cnt_d   = '0;
         tx_shift_d  = '0;
         load_pend_d = 1'b0;
         rd_cap_d    = 1'b0;
      end else begin
         if (sample_edge) begin
            rx_shift_d = rx_word[WIDTH-2:0];
            bit_cnt_d  = word_done ? '0 : bit_cnt_q + CNT_W'(1);
         end
         if (word_done) begin
            load_pend_d = 1'b1;
            unique case (state_q)
               CMD: begin
                  addr_d = rx_word[ADDR_WIDTH-1:0];
                  if (rx_word[WIDTH-1]) begin
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                     rd_en_d = 1'b1;
                  end
               end
               WRITE: begin
                  wr_en_d   = 1'b1;
                  wr_data_d = rx_word;
               end
               READ:    rd_en_d = 1'b1;
               default: ;
            endcase
         end
         // Sample and shift edges are opposite sck edges and never coincide.
         if (shift_edge) begin
            if (load_pend_q) begin
               tx_shift_d  = next_tx_q;
               load_pend_d = 1'b0;
            end else begin
               tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end
         end
      end

      // Outside READ the next transmit word is forced to zero, so miso is 0.
      if (state_q != READ) begin
         next_tx_d = '0;
      end else if (rd_cap_q) begin
         next_tx_d = rdData;
      end

      busy_d = (state_d != IDLE);
      miso_d = tx_shift_d[WIDTH-1];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         // cs flops reset low: a cs held low through reset must first go high
         // before its falling edge can start a frame.
         cs_meta_q   <= 1'b0;
         cs_sync_q   <= 1'b0;
         cs_dly_q    <= 1'b0;
         sck_meta_q  <= SCK_IDLE;
         sck_sync_q  <= SCK_IDLE;
         sck_dly_q   <= SCK_IDLE;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         next_tx_q   <= '0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_cap_q    <= 1'b0;
         load_pend_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         cs_meta_q   <= cs;
         cs_sync_q   <= cs_meta_q;
         cs_dly_q    <= cs_sync_q;
         sck_meta_q  <= sck;
         sck_sync_q  <= sck_meta_q;
         sck_dly_q   <= sck_sync_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         next_tx_q   <= next_tx_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         rd_cap_q    <= rd_cap_d;
         load_pend_q <= load_pend_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         miso_q      <= miso_d;
      end
   end

   assign miso     = miso_q;
   assign addr     = addr_q;
   assign wrData   = wr_data_q;
   assign wrEn     = wr_en_q;
   assign rdEn     = rd_en_q;
   assign busy     = busy_q;
   assign frameErr = frame_err_q;

endmodule
